// File: rtl/sle_pkg.sv
// Shared constants and types for the configurable storage cell.
package sle_pkg;

  // Storage mode selected by LAT.
  localparam logic SLE_MODE_FF    = 1'b0;
  localparam logic SLE_MODE_LATCH = 1'b1;

  // Per-bit default reset value; replicated to the cell width by the top.
  localparam logic SLE_RESET_BIT = 1'b0;

  // Source chosen by the next-value priority selector.
  typedef enum logic [2:0] {
    SelReset,
    SelLoad,
    SelSd,
    SelD,
    SelHold
  } sle_sel_e;

endpackage

// File: rtl/sle_next_mux.sv
// Priority selector computing the next stored value of the cell.
// sel_val_o never depends on q_i, so the latch path can use it without
// closing a combinational loop through the output; upd_o flags that a
// new value (not a hold) was selected.
module sle_next_mux
  import sle_pkg::*;
#(
  parameter int unsigned       Width    = 1,
  parameter logic [Width-1:0]  ResetVal = '0
) (
  input  logic             rst_i,
  input  logic             aln_i,
  input  logic             adn_i,
  input  logic             en_i,
  input  logic             sln_i,
  input  logic [Width-1:0] sd_i,
  input  logic [Width-1:0] d_i,
  input  logic [Width-1:0] q_i,
  output logic [Width-1:0] sel_val_o,
  output logic             upd_o,
  output logic [Width-1:0] nxt_o
);

  sle_sel_e sel;

  // Resolve the source, highest priority first.
  always_comb begin
    sel = SelHold;
    if (rst_i) begin
      sel = SelReset;
    end else if (!aln_i) begin
      sel = SelLoad;
    end else if (en_i) begin
      sel = sln_i ? SelD : SelSd;
    end
  end

  // Value of the selected source; the hold case is handled below.
  always_comb begin
    sel_val_o = '0;
    unique case (sel)
      SelReset: sel_val_o = ResetVal;
      SelLoad:  sel_val_o = {Width{~adn_i}};
      SelSd:    sel_val_o = sd_i;
      SelD:     sel_val_o = d_i;
      default:  sel_val_o = '0;
    endcase
  end

  assign upd_o = (sel != SelHold);
  assign nxt_o = upd_o ? sel_val_o : q_i;

endmodule

// File: rtl/sle_cell.sv
// Configurable storage cell: rising-edge flop (LAT=0) or high-transparent
// latch (LAT=1), with shared priority next-value selection.
//
// Q always comes from one output latch. In latch mode it opens while CLK is
// high and a new value is selected. In flop mode it is transparent to the
// flop, but only once the flop has captured at a rising edge in flop mode;
// this freezes Q after a latch-to-flop switch until the next rising edge.
// The latch is intentional.
module sle_cell
  import sle_pkg::*;
#(
  parameter int unsigned       WIDTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = {WIDTH{SLE_RESET_BIT}}
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             EN,
  input  logic             ALN,
  input  logic             ADN,
  input  logic             SLN,
  input  logic [WIDTH-1:0] SD,
  input  logic             LAT,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] sel_val;
  logic             upd;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] ff_q;
  logic             ff_fresh_q;
  logic [WIDTH-1:0] lat_d;
  logic             lat_en;
  logic [WIDTH-1:0] lat_q;

  sle_next_mux #(
    .Width    (WIDTH),
    .ResetVal (RESET_VAL)
  ) u_next_mux (
    .rst_i     (RST),
    .aln_i     (ALN),
    .adn_i     (ADN),
    .en_i      (EN),
    .sln_i     (SLN),
    .sd_i      (SD),
    .d_i       (D),
    .q_i       (lat_q),
    .sel_val_o (sel_val),
    .upd_o     (upd),
    .nxt_o     (nxt)
  );

  // Flop storage: capture the selected value at each rising edge in flop mode;
  // remember whether that edge was a flop-mode capture.
  always_ff @(posedge CLK) begin
    ff_fresh_q <= (LAT == SLE_MODE_FF);
    if (LAT == SLE_MODE_FF) begin
      ff_q <= nxt;
    end
  end

  // Output latch source and enable, chosen by mode.
  always_comb begin
    lat_d  = ff_q;
    lat_en = ff_fresh_q;
    if (LAT == SLE_MODE_LATCH) begin
      lat_d  = sel_val;
      lat_en = CLK & upd;
    end
  end

  // Output storage: transparent while enabled, holds otherwise.
  always_latch begin
    if (lat_en) begin
      lat_q <= lat_d;
    end
  end

  assign Q = lat_q;

endmodule

// File: tb/tb_sle_cell.sv
// Directed and randomized checks of sle_cell in flop and latch modes,
// on a 1-bit cell and an 8-bit cell with a non-zero reset value.
module tb_sle_cell;

  logic       clk;
  logic       rst;
  logic       en;
  logic       aln;
  logic       adn;
  logic       sln;
  logic       lat;
  logic       d;
  logic       sd;
  logic       q;
  logic [7:0] d8;
  logic [7:0] sd8;
  logic [7:0] q8;

  int errors;
  int checks;

  logic [7:0] m1;
  logic [7:0] m8;

  sle_cell u_dut1 (
    .CLK (clk),
    .RST (rst),
    .D   (d),
    .EN  (en),
    .ALN (aln),
    .ADN (adn),
    .SLN (sln),
    .SD  (sd),
    .LAT (lat),
    .Q   (q)
  );

  sle_cell #(
    .WIDTH     (8),
    .RESET_VAL (8'hA5)
  ) u_dut8 (
    .CLK (clk),
    .RST (rst),
    .D   (d8),
    .EN  (en),
    .ALN (aln),
    .ADN (adn),
    .SLN (sln),
    .SD  (sd8),
    .LAT (lat),
    .Q   (q8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference priority list for one update (w = cell width, rv = reset value).
  function automatic logic [7:0] ref_next(input logic r, input logic a, input logic ad,
                                          input logic e, input logic s,
                                          input logic [7:0] sdv, input logic [7:0] dv,
                                          input logic [7:0] qv, input logic [7:0] rv,
                                          input int unsigned w);
    logic [7:0] fill;
    fill = (w == 8) ? {8{~ad}} : {7'b0, ~ad};
    if (r)       return rv;
    else if (!a) return fill;
    else if (e)  return s ? dv : sdv;
    else         return qv;
  endfunction

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1; aln = 1'b1; adn = 1'b0; en = 1'b0; sln = 1'b1; lat = 1'b0;
    d = 1'b0; sd = 1'b0; d8 = 8'h00; sd8 = 8'h00;

    // Flop mode: reset, then load both polarities.
    @(negedge clk);
    @(posedge clk); #1;
    chk("ff_reset_q1", {7'b0, q}, 8'h00);
    chk("ff_reset_q8", q8, 8'hA5);

    @(negedge clk); rst = 1'b0; aln = 1'b0; adn = 1'b0;
    @(posedge clk); #1;
    chk("ff_load1_q1", {7'b0, q}, 8'h01);
    chk("ff_load1_q8", q8, 8'hFF);

    @(negedge clk); adn = 1'b1;
    @(posedge clk); #1;
    chk("ff_load0_q1", {7'b0, q}, 8'h00);
    chk("ff_load0_q8", q8, 8'h00);

    // D and SD paths.
    @(negedge clk); aln = 1'b1; en = 1'b1; sln = 1'b1; d = 1'b1; d8 = 8'h5A;
    @(posedge clk); #1;
    chk("ff_d_q1", {7'b0, q}, 8'h01);
    chk("ff_d_q8", q8, 8'h5A);

    @(negedge clk); sln = 1'b0; sd = 1'b0; d = 1'b1; sd8 = 8'h3C;
    @(posedge clk); #1;
    chk("ff_sd_q1", {7'b0, q}, 8'h00);
    chk("ff_sd_q8", q8, 8'h3C);

    // Enable low holds while D toggles.
    @(negedge clk); en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); d = ~d; d8 = ~d8;
      @(posedge clk); #1;
      chk("ff_hold_q1", {7'b0, q}, 8'h00);
      chk("ff_hold_q8", q8, 8'h3C);
    end

    // Priority: reset beats load, load beats SD.
    @(negedge clk); rst = 1'b1; aln = 1'b0; adn = 1'b0;
    @(posedge clk); #1;
    chk("prio_rst_q1", {7'b0, q}, 8'h00);
    chk("prio_rst_q8", q8, 8'hA5);

    @(negedge clk); rst = 1'b0; en = 1'b1; sln = 1'b0; sd = 1'b0; sd8 = 8'h3C;
    @(posedge clk); #1;
    chk("prio_load_q1", {7'b0, q}, 8'h01);
    chk("prio_load_q8", q8, 8'hFF);

    // Flop ignores input changes between edges.
    @(negedge clk); aln = 1'b1; sln = 1'b1; d = 1'b0; d8 = 8'h00;
    #1;
    chk("ff_between_q1", {7'b0, q}, 8'h01);
    @(posedge clk); #1;
    chk("ff_edge_q1", {7'b0, q}, 8'h00);
    chk("ff_edge_q8", q8, 8'h00);

    // Latch mode: switch while low holds, then transparency while high.
    @(negedge clk); lat = 1'b1; d = 1'b0; d8 = 8'h00;
    #1;
    chk("lat_switch_q1", {7'b0, q}, 8'h00);
    @(posedge clk); #1;
    chk("lat_high_q1", {7'b0, q}, 8'h00);
    #1; d = 1'b1; d8 = 8'h81;
    #1;
    chk("lat_transp_q1", {7'b0, q}, 8'h01);
    chk("lat_transp_q8", q8, 8'h81);
    @(negedge clk); #1;
    chk("lat_fall_q1", {7'b0, q}, 8'h01);
    d = 1'b0; d8 = 8'h00;
    #1;
    chk("lat_closed_q1", {7'b0, q}, 8'h01);
    chk("lat_closed_q8", q8, 8'h81);
    @(posedge clk); #1;
    chk("lat_rise_q1", {7'b0, q}, 8'h00);
    chk("lat_rise_q8", q8, 8'h00);
    #1; en = 1'b0; d = 1'b1; d8 = 8'hF0;
    #1;
    chk("lat_en0_q1", {7'b0, q}, 8'h00);
    chk("lat_en0_q8", q8, 8'h00);

    // Latch reset while high, then release to D.
    @(negedge clk); en = 1'b1; d = 1'b0; d8 = 8'h00;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("lat_rst_q1", {7'b0, q}, 8'h00);
    chk("lat_rst_q8", q8, 8'hA5);
    rst = 1'b0; d = 1'b1; d8 = 8'hFF;
    #1;
    chk("lat_unrst_q1", {7'b0, q}, 8'h01);
    chk("lat_unrst_q8", q8, 8'hFF);

    // Latch-to-flop switch while high freezes Q until the next rising edge.
    @(posedge clk); #1;
    lat = 1'b0; d = 1'b0; d8 = 8'h00;
    #1;
    chk("sw_freeze_q1", {7'b0, q}, 8'h01);
    chk("sw_freeze_q8", q8, 8'hFF);
    @(posedge clk); #1;
    chk("sw_flop_q1", {7'b0, q}, 8'h00);
    chk("sw_flop_q8", q8, 8'h00);

    // Known start for the random run.
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rnd_init_q1", {7'b0, q}, 8'h00);
    chk("rnd_init_q8", q8, 8'hA5);
    m1 = 8'h00;
    m8 = 8'hA5;

    // Random regression: 200 cycles flop, then 200 cycles latch.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rst = 1'b0;
      aln = 1'b1;
      lat = (i >= 200);
      en  = 1'($urandom_range(0, 1));
      sln = 1'($urandom_range(0, 1));
      d   = 1'($urandom_range(0, 1));
      sd  = 1'($urandom_range(0, 1));
      d8  = 8'($urandom_range(0, 255));
      sd8 = 8'($urandom_range(0, 255));
      m1 = ref_next(rst, aln, adn, en, sln, {7'b0, sd}, {7'b0, d}, m1, 8'h00, 1);
      m8 = ref_next(rst, aln, adn, en, sln, sd8, d8, m8, 8'hA5, 8);
      @(posedge clk); #1;
      chk(lat ? "rnd_lat_q1" : "rnd_ff_q1", {7'b0, q}, m1);
      chk(lat ? "rnd_lat_q8" : "rnd_ff_q8", q8, m8);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sle_cell.md
Name: sle_cell

Overview:
- Configurable sequential logic element: one storage cell per bit that operates as a rising-edge flip-flop (LAT=0) or a high-transparent latch (LAT=1).
- Provides synchronous reset, a priority "load" path (ALN/ADN), clock enable, and a synchronous set/clear-style data override (SLN/SD).
- Serves as the basic register primitive under generic RTL and in glue logic.

Parameters:
- WIDTH, 1, number of independent storage bits; all controls are shared across bits.
- RESET_VAL, all-zeros (WIDTH bits), value Q takes on reset.

Ports:
- CLK  input  1  clock; rising edge for flop mode, high level for latch mode.
- RST  input  1  synchronous active-high reset.
- D  input  WIDTH  functional data input.
- EN  input  1  active-high enable for the D/SD path.
- ALN  input  1  active-low load; sampled synchronously, not asynchronous.
- ADN  input  1  load data, inverted: a load writes ~ADN to every bit.
- SLN  input  1  active-low select of SD instead of D (only when EN=1).
- SD  input  WIDTH  substitute data used when SLN=0.
- LAT  input  1  mode: 0 = flip-flop, 1 = latch.
- Q  output  WIDTH  stored value.

Behaviour:
- One clock, CLK. Reset is synchronous and active-high: RST.
- Next-value selection, highest priority first; identical in both modes:
  1. RST=1 -> RESET_VAL
  2. ALN=0 -> {WIDTH{~ADN}}
  3. EN=1 and SLN=0 -> SD
  4. EN=1 and SLN=1 -> D
  5. EN=0 -> hold Q
- Flop mode (LAT=0):
  - Q updates only at the CLK rising edge with the selected value.
  - Latency is 1 edge; Q is stable between edges.
  - Input changes between edges have no effect.
- Latch mode (LAT=1):
  - While CLK=1, Q continuously follows the selected value (transparent, combinational delay only).
  - While CLK=0, Q holds the value present at the CLK falling edge.
  - EN=0 while CLK=1 holds Q.
- Reset:
  - Flop mode: RST seen at a rising edge forces RESET_VAL.
  - Latch mode: RST high while CLK=1 forces RESET_VAL.
  - RST overrides ALN, EN and SLN in the same cycle.
- Before the first reset or load, Q is undefined. Benches must apply RST or ALN=0 first.
- Simultaneous events: the priority list resolves all combinations. Example: ALN=0 with EN=1, SLN=0 loads ~ADN, not SD.
- Mode switching:
  - LAT is sampled continuously. A change takes effect immediately and Q keeps its current value at the switch.
  - Switching from latch to flop while CLK=1 freezes Q until the next rising edge.
- No glitch requirement beyond standard synthesizable latch inference. The latch mode is intentional and documented for lint waivers.

Decomposition:
- Shared package sle_pkg:
  - mode constants SLE_MODE_FF=1'b0, SLE_MODE_LATCH=1'b1
  - default RESET_VAL constant
- Sub-module sle_next_mux: purely combinational priority selector (RST, ALN/ADN, EN, SLN/SD, D, Q) -> next value.
- Top: instantiates sle_next_mux plus the flop storage and latch storage, and selects between them by LAT.

Test Plan:
- WIDTH=1, LAT=0:
  - RST=1 at an edge -> Q=0.
  - Then ALN=0, ADN=0 -> Q=1 after the next rising edge.
  - ADN=1 -> Q=0.
- LAT=0, ALN=1, EN=1:
  - SLN=1, D=1 -> Q=1 next edge.
  - SLN=0, SD=0, D=1 -> Q=0.
  - EN=0, D toggling -> Q holds for 4 edges.
- Priority: RST=1 with ALN=0, ADN=0 -> Q=0. Then RST=0, ALN=0, EN=1, SLN=0, SD=0 -> Q=1 (load beats SD).
- LAT=1, EN=1, SLN=1:
  - D changes 0->1 while CLK=1 -> Q=1 within the same high phase.
  - D changes while CLK=0 -> Q unchanged until CLK rises.
- Random regression:
  - 200 cycles with LAT=0, then 200 with LAT=1.
  - EN, SLN, SD and D randomized at each negedge, ALN=1.
  - Q is compared every cycle against a reference model of the priority list.
- WIDTH=8, RESET_VAL=8'hA5:
  - RST -> Q=8'hA5.
  - ALN=0, ADN=1 -> Q=8'h00.
  - EN=1, SLN=0, SD=8'h3C -> Q=8'h3C.
